dcache_direct: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the core's MEM stage and the word-addressed data memory.
- Load hits are served from local block RAM. Load misses and all stores go to the data memory over its single-cycle req / ready handshake.
- Cuts average load latency without changing memory contents semantics. Memory always holds the latest store.

---
 rtl/dcache_direct.sv | 228 ++++++++++++++++++++++
 tb/tb_dcache_direct.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// One 32-bit word per line. Load hits are answered from local block RAM;
// load misses and every store go to the data memory through a one-cycle
// req pulse followed by a ready response. Memory always holds the latest store.
module dcache_direct #(
  parameter int INDEX_BITS = 10,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic        cpu_flush,
  output logic [31:0] cpu_rd,
  output logic        cpu_done,
  output logic        cpu_busy,
  output logic [31:0] mem_a,
  output logic        mem_req,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  input  logic        mem_ready
);

  localparam int LINES = 2 ** INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    ISSUE  = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t state, state_next;

  // Request latched at acceptance; the core may change its inputs afterwards.
  logic                  req_we;
  logic [29:0]           req_wa;
  logic [31:0]           req_wd;
  logic                  req_hit;

  logic [INDEX_BITS-1:0] cpu_idx;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;

  // Storage: data and tag in synchronous-read RAM, valid bits in flops.
  logic [31:0]           data_mem [LINES];
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [LINES-1:0]      valid;

  // Control strobes from the next-state logic.
  logic                  accept;
  logic                  flush;
  logic                  fill;
  logic                  data_wr_en;
  logic [31:0]           data_wr_val;
  logic                  lookup_hit;

  // Registered-output next values.
  logic [31:0]           cpu_rd_next;
  logic                  cpu_done_next;
  logic                  cpu_busy_next;
  logic [31:0]           mem_a_next;
  logic                  mem_req_next;
  logic [31:0]           mem_wd_next;
  logic                  mem_we_next;

  // Byte-offset bits of the address carry no information for a word cache.
  logic                  addr_lsb_unused;
  assign addr_lsb_unused = ^cpu_addr[1:0];

  assign cpu_idx    = cpu_addr[INDEX_BITS+1:2];
  assign req_idx    = req_wa[INDEX_BITS-1:0];
  assign req_tag    = req_wa[29:INDEX_BITS];
  assign lookup_hit = valid[req_idx] && (tag_q == req_tag);

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, output and array-update decisions.
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    flush         = 1'b0;
    fill          = 1'b0;
    data_wr_en    = 1'b0;
    data_wr_val   = mem_rd;
    cpu_rd_next   = cpu_rd;
    cpu_done_next = 1'b0;
    cpu_busy_next = cpu_busy;
    mem_a_next    = mem_a;
    mem_req_next  = 1'b0;
    mem_wd_next   = mem_wd;
    mem_we_next   = 1'b0;
    case (state)
      IDLE: begin
        cpu_busy_next = 1'b0;
        if (cpu_flush) begin
          // Flush wins; a simultaneous request is dropped.
          flush = 1'b1;
        end else if (cpu_req) begin
          accept        = 1'b1;
          cpu_busy_next = 1'b1;
          state_next    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!req_we && lookup_hit) begin
          cpu_rd_next   = data_q;
          cpu_done_next = 1'b1;
          cpu_busy_next = 1'b0;
          state_next    = IDLE;
        end else begin
          mem_req_next = 1'b1;
          mem_we_next  = req_we;
          mem_a_next   = {req_wa, 2'b00};
          mem_wd_next  = req_wd;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        // The memory mis-handles a req still high during its ready cycle,
        // so the pulse is dropped here, before ready can arrive.
        state_next = WAIT;
      end
      WAIT: begin
        if (mem_ready) begin
          cpu_done_next = 1'b1;
          cpu_busy_next = 1'b0;
          state_next    = IDLE;
          if (!req_we) begin
            fill        = 1'b1;
            data_wr_en  = 1'b1;
            data_wr_val = mem_rd;
            cpu_rd_next = mem_rd;
          end else if (req_hit) begin
            // Keep a cached copy coherent with the write-through store.
            data_wr_en  = 1'b1;
            data_wr_val = req_wd;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the accepted request and remember the lookup result for stores.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_we  <= 1'b0;
      req_wa  <= '0;
      req_wd  <= '0;
      req_hit <= 1'b0;
    end else begin
      if (accept) begin
        req_we <= cpu_we;
        req_wa <= cpu_addr[31:2];
        req_wd <= cpu_wd;
      end
      if (state == LOOKUP) begin
        req_hit <= lookup_hit;
      end
    end
  end

  // Data RAM: read started on acceptance, written on fill or store hit.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= data_mem[cpu_idx];
    end
    if (data_wr_en) begin
      data_mem[req_idx] <= data_wr_val;
    end
  end

  // Tag RAM: read alongside data, written only by a load fill.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q <= tag_mem[cpu_idx];
    end
    if (fill) begin
      tag_mem[req_idx] <= req_tag;
    end
  end

  // Valid flops: cleared in one cycle by reset or flush, set by a fill.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      valid <= '0;
    end else if (fill) begin
      valid[req_idx] <= 1'b1;
    end
  end

  // Registered core and memory outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cpu_rd   <= '0;
      cpu_done <= 1'b0;
      cpu_busy <= 1'b0;
      mem_a    <= '0;
      mem_req  <= 1'b0;
      mem_wd   <= '0;
      mem_we   <= 1'b0;
    end else begin
      cpu_rd   <= cpu_rd_next;
      cpu_done <= cpu_done_next;
      cpu_busy <= cpu_busy_next;
      mem_a    <= mem_a_next;
      mem_req  <= mem_req_next;
      mem_wd   <= mem_wd_next;
      mem_we   <= mem_we_next;
    end
  end

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct: directed scenarios followed by a
// random load/store/flush stream compared against a word-level memory model
// plus a record of which word address each cache line last filled from.
module tb_dcache_direct;

  localparam int IB = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wd = '0;
  logic        cpu_flush = 1'b0;
  logic [31:0] cpu_rd;
  logic        cpu_done;
  logic        cpu_busy;
  logic [31:0] mem_a;
  logic        mem_req;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd = '0;
  logic        mem_ready = 1'b0;

  dcache_direct #(.INDEX_BITS(IB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wd    (cpu_wd),
    .cpu_flush (cpu_flush),
    .cpu_rd    (cpu_rd),
    .cpu_done  (cpu_done),
    .cpu_busy  (cpu_busy),
    .mem_a     (mem_a),
    .mem_req   (mem_req),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int resp_delay = 0;

  // Data memory seen by the responder, and the reference model's own copy.
  logic [31:0] ram     [bit [29:0]];
  logic [31:0] ref_mem [bit [29:0]];
  // Reference cache: line index -> word address currently held.
  bit   [29:0] ref_line [int];
  logic [31:0] last_rd = '0;

  function automatic logic [31:0] dflt(input bit [29:0] wa);
    return ({2'b00, wa} * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] ram_get(input bit [29:0] wa);
    return ram.exists(wa) ? ram[wa] : dflt(wa);
  endfunction

  function automatic logic [31:0] ref_get(input bit [29:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : dflt(wa);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Data memory: answers one cycle after a req (plus resp_delay), returns
  // garbage on mem_rd whenever it is not presenting a valid word.
  initial begin : responder
    bit [29:0]   wa;
    logic        we;
    logic [31:0] wd;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        wa = mem_a[31:2];
        we = mem_we;
        wd = mem_wd;
        @(posedge clk);
        repeat (resp_delay) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        mem_rd    = we ? $urandom : ram_get(wa);
        if (we) ram[wa] = wd;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_rd    = $urandom;
      end
    end
  end

  // One load or store; starts and ends at a negedge with the cache idle.
  task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd_o, output int nreq_o);
    bit [29:0]   wa;
    int          idx;
    bit          exp_hit;
    logic [31:0] exp_rd;
    int          k;
    int          req_k;
    int          nreq;
    bit          done;
    wa      = addr[31:2];
    idx     = int'(addr[IB+1:2]);
    exp_hit = !we && ref_line.exists(idx) && (ref_line[idx] == wa);
    exp_rd  = we ? last_rd : ref_get(wa);
    rd_o    = 'x;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wd = wd; cpu_flush = 1'b0;
    @(posedge clk);
    #1;
    cpu_req  = 1'b0;
    cpu_we   = 1'($urandom_range(0, 1));
    cpu_addr = $urandom;
    cpu_wd   = $urandom;
    k = 0; req_k = 0; nreq = 0; done = 1'b0;
    while (!done && k < 24) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check_val("busy_after_accept", {31'b0, cpu_busy}, 32'd1);
        check_val("done_single_cycle", {31'b0, cpu_done}, 32'd0);
        // Requests and flushes while busy must be ignored.
        cpu_req   = 1'($urandom_range(0, 1));
        cpu_flush = 1'($urandom_range(0, 1));
      end else if (k == 2) begin
        cpu_req   = 1'b0;
        cpu_flush = 1'b0;
      end
      if (mem_req === 1'b1) begin
        nreq++;
        if (req_k == 0) req_k = k;
        check_val("mem_a", mem_a, {addr[31:2], 2'b00});
        check_val("mem_we", {31'b0, mem_we}, {31'b0, we});
        if (we) check_val("mem_wd", mem_wd, wd);
      end
      if (cpu_done === 1'b1) begin
        done = 1'b1;
        rd_o = cpu_rd;
        check_val("cpu_rd", cpu_rd, exp_rd);
        check_val("busy_at_done", {31'b0, cpu_busy}, 32'd0);
      end
    end
    check_val("done_seen", {31'b0, done}, 32'd1);
    check_val("done_latency", 32'(k), exp_hit ? 32'd2 : 32'(4 + resp_delay));
    check_val("req_latency", 32'(req_k), exp_hit ? 32'd0 : 32'd2);
    check_val("req_count", 32'(nreq), exp_hit ? 32'd0 : 32'd1);
    if (we) begin
      ref_mem[wa] = wd;
    end else begin
      ref_line[idx] = wa;
      last_rd = exp_rd;
    end
    nreq_o = nreq;
    $display("op %s addr=%h wd=%h rd=%h mem_reqs=%0d latency=%0d",
             we ? "ST" : "LD", addr, wd, rd_o, nreq, k);
  endtask

  // Flush, optionally together with a request that must be dropped.
  task automatic do_flush(input bit with_req);
    cpu_flush = 1'b1; cpu_req = with_req; cpu_we = 1'b0; cpu_addr = 32'h100;
    @(negedge clk);
    cpu_flush = 1'b0; cpu_req = 1'b0;
    check_val("flush_no_done", {31'b0, cpu_done}, 32'd0);
    check_val("flush_not_busy", {31'b0, cpu_busy}, 32'd0);
    @(negedge clk);
    check_val("flush_no_done2", {31'b0, cpu_done}, 32'd0);
    check_val("flush_no_req", {31'b0, mem_req}, 32'd0);
    ref_line.delete();
    $display("op FL with_req=%0d", with_req);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [19:0] tag;
    logic [9:0]  idx;
    logic [1:0]  lsb;
    case ($urandom_range(0, 3))
      0: tag = 20'h00000;
      1: tag = 20'h00001;
      2: tag = 20'h00002;
      default: tag = 20'hFFFFF;
    endcase
    idx = ($urandom_range(0, 4) == 4) ? 10'h3FF : 10'($urandom_range(0, 3));
    lsb = 2'($urandom_range(0, 3));
    return {tag, idx, lsb};
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] rd;
    int          nreq;
    ram[30'h40]     = 32'hDEADBEEF;
    ref_mem[30'h40] = 32'hDEADBEEF;

    // Reset state.
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_cpu_done", {31'b0, cpu_done}, 32'd0);
    check_val("rst_cpu_busy", {31'b0, cpu_busy}, 32'd0);
    check_val("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check_val("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check_val("rst_cpu_rd", cpu_rd, 32'd0);
    check_val("rst_mem_a", mem_a, 32'd0);
    check_val("rst_mem_wd", mem_wd, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Miss then hit on 0x100.
    do_op(1'b0, 32'h100, 32'h0, rd, nreq);
    check_val("t1_miss_rd", rd, 32'hDEADBEEF);
    check_val("t1_miss_req", 32'(nreq), 32'd1);
    do_op(1'b0, 32'h100, 32'h0, rd, nreq);
    check_val("t1_hit_rd", rd, 32'hDEADBEEF);
    check_val("t1_hit_req", 32'(nreq), 32'd0);

    // Store hit updates the cached word.
    do_op(1'b1, 32'h100, 32'h12345678, rd, nreq);
    check_val("t2_store_rd_kept", rd, 32'hDEADBEEF);
    do_op(1'b0, 32'h100, 32'h0, rd, nreq);
    check_val("t2_hit_rd", rd, 32'h12345678);
    check_val("t2_hit_req", 32'(nreq), 32'd0);

    // No-write-allocate.
    do_op(1'b1, 32'h200, 32'hA5A5A5A5, rd, nreq);
    do_op(1'b0, 32'h200, 32'h0, rd, nreq);
    check_val("t3_rd", rd, 32'hA5A5A5A5);
    check_val("t3_req", 32'(nreq), 32'd1);

    // Conflict eviction on index 0.
    do_op(1'b0, 32'h0000, 32'h0, rd, nreq);
    do_op(1'b0, 32'h1000, 32'h0, rd, nreq);
    check_val("t4_second_req", 32'(nreq), 32'd1);
    do_op(1'b0, 32'h0000, 32'h0, rd, nreq);
    check_val("t4_third_req", 32'(nreq), 32'd1);
    check_val("t4_rd", rd, dflt(30'h0));

    // Top address, back-to-back requests.
    do_op(1'b0, 32'hFFFFFFFC, 32'h0, rd, nreq);
    do_op(1'b0, 32'hFFFFFFFF, 32'h0, rd, nreq);
    check_val("t5_top_hit_req", 32'(nreq), 32'd0);

    // Flush with a simultaneous request; request dropped, line invalid.
    do_op(1'b0, 32'h100, 32'h0, rd, nreq);
    do_flush(1'b1);
    do_op(1'b0, 32'h100, 32'h0, rd, nreq);
    check_val("t6_after_flush_req", 32'(nreq), 32'd1);

    // Reset during a load miss, memory answering as reset releases.
    do_op(1'b0, 32'h300, 32'h0, rd, nreq);
    do_flush(1'b0);
    resp_delay = 1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("t7_mem_req", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("t7_no_done", {31'b0, cpu_done}, 32'd0);
      check_val("t7_not_busy", {31'b0, cpu_busy}, 32'd0);
    end
    check_val("t7_cpu_rd_reset", cpu_rd, 32'd0);
    resp_delay = 0;
    ref_line.delete();
    last_rd = '0;
    $display("op RST during load miss");
    do_op(1'b0, 32'h300, 32'h0, rd, nreq);
    check_val("t7_reload_req", 32'(nreq), 32'd1);
    do_op(1'b0, 32'h100, 32'h0, rd, nreq);
    check_val("t7_valid_cleared", 32'(nreq), 32'd1);

    // Random stream.
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        do_flush(1'($urandom_range(0, 1)));
      end else if (sel < 8) begin
        do_op(1'b1, rand_addr(), $urandom, rd, nreq);
      end else begin
        do_op(1'b0, rand_addr(), $urandom, rd, nreq);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
